inst_mem_responder: RTL and testbench

INST_MEM_RESPONDER -- requirements
Module: inst_mem_responder

---
 rtl/inst_mem_responder.sv | 144 ++++++++++++++
 tb/tb_inst_mem_responder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/inst_mem_responder.sv
// Instruction-memory burst responder: streams BURST_LEN little-endian words from a byte RAM.
// Define INST_MEM_RESPONDER_ABORT_EN to let reset_from_fetcher abort a burst.
module inst_mem_responder #(
  parameter int unsigned BURST_LEN = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        enable_from_fetcher,
  input  logic [31:0] address_from_fetcher,
  input  logic        reset_from_fetcher,
  input  logic [7:0]  mem_din,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  output logic [31:0] inst_to_fetcher,
  output logic        one_inst_finish_to_fetcher,
  output logic        end_to_fetcher
);

  localparam logic [9:0] LastByte = 10'(4 * BURST_LEN - 1);
  localparam logic [9:0] AllBytes = 10'(4 * BURST_LEN);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] base_q, mem_a_q, inst_q;
  logic [9:0]  issue_q, cap_q;
  logic [23:0] bytes_q;
  logic        prime_q, pulse_q, end_q;
  logic        abort_req, abort, capture, all_done;

`ifdef INST_MEM_RESPONDER_ABORT_EN
  assign abort_req = reset_from_fetcher;
`else
  logic unused_abort;
  assign unused_abort = reset_from_fetcher;
  assign abort_req    = 1'b0;
`endif

  assign abort    = rdy_in & abort_req;
  assign all_done = (cap_q == AllBytes);
  // prime_q marks that mem_din holds the byte for base + cap_q this cycle.
  assign capture  = (state_q == StBusy) & rdy_in & prime_q & ~all_done;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = StIdle;
    end else if (rdy_in) begin
      unique case (state_q)
        StIdle:  if (enable_from_fetcher) state_d = StBusy;
        StBusy:  if (all_done) state_d = StDone;
        StDone:  if (!enable_from_fetcher) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      base_q  <= '0;
      mem_a_q <= '0;
      inst_q  <= '0;
      issue_q <= '0;
      cap_q   <= '0;
      bytes_q <= '0;
      prime_q <= 1'b0;
      pulse_q <= 1'b0;
      end_q   <= 1'b0;
    end else if (abort) begin
      base_q  <= '0;
      mem_a_q <= '0;
      inst_q  <= '0;
      issue_q <= '0;
      cap_q   <= '0;
      bytes_q <= '0;
      prime_q <= 1'b0;
      pulse_q <= 1'b0;
      end_q   <= 1'b0;
    end else if (!rdy_in) begin
      // Rewind issue to the oldest uncaptured byte; the resume edge is a bubble.
      if (state_q == StBusy && !all_done) begin
        issue_q <= cap_q;
        mem_a_q <= base_q + 32'(cap_q);
        prime_q <= 1'b0;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (enable_from_fetcher) begin
            base_q  <= address_from_fetcher & 32'hFFFF_FFFC;
            mem_a_q <= address_from_fetcher & 32'hFFFF_FFFC;
            issue_q <= '0;
            cap_q   <= '0;
            prime_q <= 1'b0;
          end
        end
        StBusy: begin
          pulse_q <= 1'b0;
          prime_q <= 1'b1;
          if (issue_q != LastByte) begin
            issue_q <= issue_q + 10'd1;
            mem_a_q <= base_q + 32'(issue_q + 10'd1);
          end
          if (capture) begin
            cap_q <= cap_q + 10'd1;
            if (cap_q[1:0] == 2'd3) begin
              inst_q  <= {mem_din, bytes_q};
              pulse_q <= 1'b1;
            end else begin
              bytes_q[{cap_q[1:0], 3'b000} +: 8] <= mem_din;
            end
          end
          if (all_done) end_q <= 1'b1;
        end
        StDone: begin
          if (!enable_from_fetcher) begin
            end_q   <= 1'b0;
            mem_a_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_a = mem_a_q;
    if (state_q == StBusy && !rdy_in && !all_done) mem_a = base_q + 32'(cap_q);
    mem_wr                     = 1'b0;
    inst_to_fetcher            = inst_q;
    one_inst_finish_to_fetcher = pulse_q & rdy_in;
    end_to_fetcher             = end_q;
  end

endmodule

// File: tb/tb_inst_mem_responder.sv
// Directed bench for inst_mem_responder (BURST_LEN 8); RAM byte at address a reads as a[7:0].
module tb_inst_mem_responder;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        enable_from_fetcher = 1'b0;
  logic [31:0] address_from_fetcher = '0;
  logic        reset_from_fetcher = 1'b0;
  logic [7:0]  mem_din = '0;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [31:0] inst_to_fetcher;
  logic        one_inst_finish_to_fetcher;
  logic        end_to_fetcher;

  int n_checks = 0;
  int n_fail   = 0;

  inst_mem_responder #(.BURST_LEN(8)) dut (
    .clk_in                     (clk_in),
    .rst_in                     (rst_in),
    .rdy_in                     (rdy_in),
    .enable_from_fetcher        (enable_from_fetcher),
    .address_from_fetcher       (address_from_fetcher),
    .reset_from_fetcher         (reset_from_fetcher),
    .mem_din                    (mem_din),
    .mem_a                      (mem_a),
    .mem_wr                     (mem_wr),
    .inst_to_fetcher            (inst_to_fetcher),
    .one_inst_finish_to_fetcher (one_inst_finish_to_fetcher),
    .end_to_fetcher             (end_to_fetcher)
  );

  initial forever #5 clk_in = ~clk_in;

  always @(posedge clk_in) mem_din <= mem_a[7:0];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    logic [7:0] b0;
    b0 = a[7:0];
    return {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
  endfunction

  function automatic int exp_edge(input int p, input int stall_at);
    int e;
    e = 4 * p + 5;
    if (stall_at > 0 && e >= stall_at) e += 4;
    return e;
  endfunction

  // stall_at: rdy low for edges stall_at..stall_at+2; abort_at: reset_from_fetcher at that edge;
  // kill_at: rst_in pulsed low right after that edge.
  task automatic burst(input logic [31:0] addr, input int stall_at, input int abort_at,
                       input int kill_at);
    logic [31:0] base;
    int npulse, exp_n, end_edge, e;
    bit aborting;
    base     = addr & 32'hFFFF_FFFC;
    aborting = 1'b0;
`ifdef INST_MEM_RESPONDER_ABORT_EN
    if (abort_at > 0) aborting = 1'b1;
`endif
    @(negedge clk_in);
    enable_from_fetcher  = 1'b1;
    address_from_fetcher = addr;
    rdy_in               = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    address_from_fetcher = 32'hDEAD_BEE0;
    check("mem_a_base", mem_a, base);
    npulse   = 0;
    end_edge = 0;
    for (int k = 1; k <= 45; k++) begin
      rdy_in = !(stall_at > 0 && k >= stall_at && k < stall_at + 3);
      reset_from_fetcher = (k == abort_at);
      if (k == abort_at) enable_from_fetcher = 1'b0;
      @(posedge clk_in);
      @(negedge clk_in);
      if (one_inst_finish_to_fetcher) begin
        check("word", inst_to_fetcher, exp_word(base + 32'(4 * npulse)));
        check("pulse_edge", 32'(k), 32'(exp_edge(npulse, stall_at)));
        npulse++;
      end
      if (stall_at == 0 && k <= 8) check("mem_a_seq", mem_a, base + 32'(k));
      if (stall_at > 0 && k == stall_at) check("mem_a_stall", mem_a, base + 32'(stall_at - 2));
      if (stall_at == 0 && abort_at == 0 && k == 7)
        check("inst_hold", inst_to_fetcher, exp_word(base));
      if (k == abort_at) begin
        if (aborting) begin
          check("abort_mem_a", mem_a, 32'h0);
          check("abort_inst", inst_to_fetcher, 32'h0);
        end else begin
          check("noabort_mem_a", mem_a, base + 32'(k));
        end
      end
      if (end_to_fetcher) begin
        end_edge = k;
        break;
      end
      if (k == kill_at) begin
        rst_in = 1'b0;
        #1;
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_inst", inst_to_fetcher, 32'h0);
        check("rst_pulse", {31'h0, one_inst_finish_to_fetcher}, 32'h0);
        check("rst_end", {31'h0, end_to_fetcher}, 32'h0);
        @(negedge clk_in);
        enable_from_fetcher = 1'b0;
        rst_in = 1'b1;
        break;
      end
    end
    reset_from_fetcher = 1'b0;
    exp_n = 0;
    for (int p = 0; p < 8; p++) begin
      e = exp_edge(p, stall_at);
      if ((!aborting || e < abort_at) && (kill_at == 0 || e <= kill_at)) exp_n++;
    end
    check("pulse_count", 32'(npulse), 32'(exp_n));
    check("end_edge", 32'(end_edge),
          (aborting || kill_at > 0) ? 32'h0 : 32'(34 + ((stall_at > 0) ? 4 : 0)));
    check("mem_wr", {31'h0, mem_wr}, 32'h0);
    if (end_edge > 0) begin
      @(negedge clk_in);
      enable_from_fetcher = 1'b0;
      @(posedge clk_in);
      @(negedge clk_in);
      check("end_clear", {31'h0, end_to_fetcher}, 32'h0);
      check("idle_mem_a", mem_a, 32'h0);
    end
  endtask

  initial begin
    #2;
    check("reset_mem_a", mem_a, 32'h0);
    check("reset_inst", inst_to_fetcher, 32'h0);
    check("reset_end", {31'h0, end_to_fetcher}, 32'h0);
    check("reset_pulse", {31'h0, one_inst_finish_to_fetcher}, 32'h0);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    check("idle_mem_a0", mem_a, 32'h0);

    burst(32'h0000_0000, 0, 0, 0);
    burst(32'h0000_0013, 0, 0, 0);
    burst(32'hFFFF_FFFC, 0, 0, 0);
    burst(32'h0000_0000, 7, 0, 0);
    burst(32'h0000_0020, 0, 10, 0);
    burst(32'h0000_0000, 0, 0, 12);
    burst(32'h0000_0040, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
